// File: rtl/mandelbrot_frame_sequencer.sv
// Frame controller for the mandelbrot iteration core: issues run pulses, buffers
// per-pixel iteration values in a small FIFO and steps the view between frames.
module mandelbrot_frame_sequencer #(
    parameter int unsigned BITWIDTH   = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                cont,
    input  logic                auto_zoom,
    input  logic [6:0]          cfg_scaling,
    input  logic [BITWIDTH-1:0] cfg_cr,
    input  logic [BITWIDTH-1:0] cfg_ci,
    input  logic [BITWIDTH-1:0] zoom_dcr,
    input  logic [BITWIDTH-1:0] zoom_dci,
    output logic                core_run,
    input  logic                core_running,
    input  logic                core_finished,
    input  logic [3:0]          core_ctr_out,
    output logic [6:0]          core_scaling,
    output logic [BITWIDTH-1:0] core_cr_offset,
    output logic [BITWIDTH-1:0] core_ci_offset,
    output logic [3:0]          pix_data,
    output logic                pix_last,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          frame_count
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        FRAME_END
    } state_t;

    state_t               state_q, state_d;
    logic                 stop_pending_q;
    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 fifo_has_space;
    logic                 push, pop, load_cfg;

    assign fifo_has_space = count_q < CNT_W'(FIFO_DEPTH);
    assign pix_valid      = count_q != '0;
    assign pop            = pix_valid && pix_ready;
    assign pix_data       = fifo_mem[rd_ptr_q][ENTRY_W-1:1];
    assign pix_last       = fifo_mem[rd_ptr_q][0];
    assign busy           = state_q != IDLE;
    assign frame_done     = state_q == FRAME_END;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and run/push decode; run is only issued when a FIFO slot is free
    always_comb begin
        state_d  = state_q;
        core_run = 1'b0;
        push     = 1'b0;
        load_cfg = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (fifo_has_space) begin
                    core_run = 1'b1;
                    state_d  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (core_running) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!core_running) begin
                    push    = 1'b1;
                    state_d = core_finished ? FRAME_END : ISSUE;
                end
            end
            FRAME_END: begin
                // A stop arriving in this very cycle still ends the run here
                state_d = (cont && !stop_pending_q && !stop) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_pending_q <= 1'b0;
        end else if (state_q == IDLE) begin
            stop_pending_q <= 1'b0;
        end else if (stop) begin
            stop_pending_q <= 1'b1;
        end
    end

    // Output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= {core_ctr_out, core_finished};
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // View configuration: loaded on frame start, stepped at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_scaling   <= '0;
            core_cr_offset <= '0;
            core_ci_offset <= '0;
            frame_count    <= '0;
        end else if (load_cfg) begin
            core_scaling   <= cfg_scaling;
            core_cr_offset <= cfg_cr;
            core_ci_offset <= cfg_ci;
        end else if (state_q == FRAME_END) begin
            frame_count <= frame_count + 8'd1;
            if (auto_zoom) begin
                if (core_scaling != '0) begin
                    core_scaling <= core_scaling - 7'd1;
                end
                core_cr_offset <= core_cr_offset + zoom_dcr;
                core_ci_offset <= core_ci_offset + zoom_dci;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame_sequencer.sv
// Scoreboard bench for mandelbrot_frame_sequencer with a behavioural 4x2 core model.
module tb_mandelbrot_frame_sequencer;

    localparam int unsigned BW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, cont = 1'b0, auto_zoom = 1'b0;
    logic [6:0]    cfg_scaling = '0;
    logic [BW-1:0] cfg_cr = '0, cfg_ci = '0, zoom_dcr = '0, zoom_dci = '0;
    logic          core_run;
    logic          core_running, core_finished;
    logic [3:0]    core_ctr_out;
    logic [6:0]    core_scaling;
    logic [BW-1:0] core_cr_offset, core_ci_offset;
    logic [3:0]    pix_data;
    logic          pix_last, pix_valid;
    logic          pix_ready = 1'b1;
    logic          busy, frame_done;
    logic [7:0]    frame_count;

    int checks = 0;
    int fails = 0;
    int run_cnt = 0;
    int pop_cnt = 0;
    int extra_lat = 0;
    logic [4:0] exp_q[$];

    // Per-pixel iteration values of the modelled 4x2 frame, XORed with the frame index
    logic [3:0] pix_vals [8] = '{4'd3, 4'd1, 4'd0, 4'd2, 4'd3, 4'd3, 4'd1, 4'd15};

    mandelbrot_frame_sequencer #(.BITWIDTH(BW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .auto_zoom(auto_zoom), .cfg_scaling(cfg_scaling), .cfg_cr(cfg_cr),
        .cfg_ci(cfg_ci), .zoom_dcr(zoom_dcr), .zoom_dci(zoom_dci),
        .core_run(core_run), .core_running(core_running),
        .core_finished(core_finished), .core_ctr_out(core_ctr_out),
        .core_scaling(core_scaling), .core_cr_offset(core_cr_offset),
        .core_ci_offset(core_ci_offset), .pix_data(pix_data),
        .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Core model: run for a few cycles, then drop running with ctr_out/finished valid
    logic [2:0] pix_idx;
    logic [3:0] model_frame;
    int         lat_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_running  <= 1'b0;
            core_finished <= 1'b0;
            core_ctr_out  <= '0;
            pix_idx       <= '0;
            model_frame   <= '0;
            lat_cnt       <= 0;
        end else if (core_run) begin
            core_running  <= 1'b1;
            core_finished <= 1'b0;
            lat_cnt       <= 1 + int'(pix_idx) % 3 + extra_lat;
        end else if (core_running) begin
            if (lat_cnt == 0) begin
                core_running  <= 1'b0;
                core_ctr_out  <= pix_vals[pix_idx] ^ model_frame;
                core_finished <= (pix_idx == 3'd7);
                exp_q.push_back({pix_vals[pix_idx] ^ model_frame, pix_idx == 3'd7});
                pix_idx       <= pix_idx + 3'd1;
                if (pix_idx == 3'd7) model_frame <= model_frame + 4'd1;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Monitor: compare every accepted pixel against the scoreboard
    always @(negedge clk) begin
        if (rst_n && core_run) run_cnt++;
        if (rst_n && pix_valid && pix_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("pix_unexpected", 1, 0);
            end else begin
                chk("pix_data_last", int'({pix_data, pix_last}), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (n < max) begin
            @(posedge clk); #1;
            if (!busy && !pix_valid) break;
            n++;
        end
        if (n >= max) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_frame_done(input string name, input int max);
        int n = 0;
        while (n < max) begin
            @(negedge clk);
            if (frame_done) break;
            n++;
        end
        if (n >= max) chk({name, "_timeout"}, 0, 1);
    endtask

    int r0, p0, f0, fd_cnt;
    always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

    initial begin
        fd_cnt = 0;
        // Reset state
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_run", int'(core_run), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_scaling", int'(core_scaling), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        #20 rst_n = 1'b1;

        // Single frame
        cfg_scaling = 7'd9; cfg_cr = 10'd77; cfg_ci = 10'd300;
        r0 = run_cnt; p0 = pop_cnt; f0 = fd_cnt;
        pulse_start();
        chk("cfg_scaling_latch", int'(core_scaling), 9);
        chk("cfg_cr_latch", int'(core_cr_offset), 77);
        chk("cfg_ci_latch", int'(core_ci_offset), 300);
        wait_idle("frame1", 300);
        chk("frame1_runs", run_cnt - r0, 8);
        chk("frame1_pixels", pop_cnt - p0, 8);
        chk("frame1_done_pulses", fd_cnt - f0, 1);
        chk("frame1_count", int'(frame_count), 1);
        chk("frame1_busy", int'(busy), 0);

        // Back-pressure: FIFO fills after exactly four run pulses
        pix_ready = 1'b0;
        r0 = run_cnt; p0 = pop_cnt;
        pulse_start();
        repeat (80) @(posedge clk);
        #1;
        chk("bp_runs", run_cnt - r0, 4);
        chk("bp_run_low", int'(core_run), 0);
        chk("bp_valid", int'(pix_valid), 1);
        pix_ready = 1'b1;
        wait_idle("bp", 300);
        chk("bp_runs_total", run_cnt - r0, 8);
        chk("bp_pixels", pop_cnt - p0, 8);
        chk("bp_count", int'(frame_count), 2);

        // Continuous auto-zoom with saturation and modulo offset wrap
        cont = 1'b1; auto_zoom = 1'b1;
        cfg_scaling = 7'd1; cfg_cr = 10'd3; cfg_ci = 10'h3FF;
        zoom_dcr = 10'h3FE; zoom_dci = 10'd1;
        pulse_start();
        for (int f = 1; f <= 3; f++) begin
            wait_frame_done("zoom", 400);
            @(posedge clk); #1;
            chk("zoom_scaling", int'(core_scaling), 0);
            chk("zoom_cr", int'(core_cr_offset), (3 - 2 * f) & 10'h3FF);
            chk("zoom_ci", int'(core_ci_offset), (10'h3FF + f) & 10'h3FF);
        end
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle("zoom_stop", 400);
        chk("zoom_count", int'(frame_count), 6);
        auto_zoom = 1'b0;

        // Stop mid frame 2; start during a frame is ignored
        r0 = run_cnt; f0 = fd_cnt;
        cfg_scaling = 7'd20;
        pulse_start();
        wait_frame_done("stop_f1", 400);
        repeat (10) @(posedge clk);
        #1 stop = 1'b1; cfg_scaling = 7'd55; start = 1'b1;
        @(posedge clk); #1 stop = 1'b0; start = 1'b0;
        chk("stop_start_ignored", int'(core_scaling), 20);
        wait_idle("stop", 400);
        chk("stop_frames", fd_cnt - f0, 2);
        chk("stop_count", int'(frame_count), 8);
        repeat (30) @(posedge clk);
        #1;
        chk("stop_no_more_runs", run_cnt - r0, 16);
        chk("stop_idle", int'(busy), 0);
        cont = 1'b0;

        // Ready toggling every cycle
        p0 = pop_cnt;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 pix_ready = ~pix_ready;
            if (!busy && !pix_valid) break;
        end
        pix_ready = 1'b1;
        wait_idle("toggle", 200);
        chk("toggle_pixels", pop_cnt - p0, 8);
        chk("toggle_queue_empty", exp_q.size(), 0);

        // Async reset while waiting for the core
        extra_lat = 6;
        pulse_start();
        begin
            int n = 0;
            while (!core_running && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) chk("rst_wait_timeout", 0, 1);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(pix_valid), 0);
        chk("midrst_run", int'(core_run), 0);
        chk("midrst_count", int'(frame_count), 0);
        exp_q.delete();
        extra_lat = 0;
        #20 rst_n = 1'b1;
        p0 = pop_cnt; r0 = run_cnt;
        pulse_start();
        wait_idle("post_rst", 300);
        chk("post_rst_pixels", pop_cnt - p0, 8);
        chk("post_rst_runs", run_cnt - r0, 8);
        chk("post_rst_count", int'(frame_count), 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
